shared_alu_arbiter: RTL and testbench
=====================================

SHARED_ALU_ARBITER -- requirements
Module: shared_alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (unsigned).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1  requester n presents an operation.
REQ-005 SHALL have ports req0_op, req1_op  input  2  opcode: 0 SUB, 1 MUL, 2 DIV, 3 MOD.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands (a op b).
REQ-007 SHALL have ports req0_ready, req1_ready  output  1  acceptance strobe; transfer occurs when valid and ready are both high at a clock edge.
REQ-008 SHALL have port rsp_valid  output  1  one-cycle result strobe; no back-pressure.
REQ-009 SHALL have port rsp_id  output  1  requester index owning the response.
REQ-010 SHALL have port rsp_result  output  WIDTH  result.
REQ-011 SHALL have port rsp_err  output  1  operation error (divide by zero or unsupported op).

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, RESP; a single shared arithmetic unit serves both requesters.
REQ-013 SHALL drive reqN_ready combinationally high only in IDLE, for at most one requester, chosen by arbitration.
REQ-014 SHALL arbitrate round-robin: the requester with priority wins when valid, else the other; after each grant, priority moves to the non-granted requester.
REQ-015 SHALL capture op, a, b and the requester id on acceptance; later changes to request inputs SHALL NOT affect the operation in flight.
REQ-016 SHALL, for SUB, produce (a - b) mod 2^WIDTH; for MUL, the low WIDTH bits of a*b; both go IDLE->RESP, with rsp_valid in the cycle after acceptance.
REQ-017 SHALL, for DIV/MOD with b != 0, run an iterative restoring divider, go IDLE->BUSY for exactly WIDTH cycles, then BUSY->RESP; result is floor(a/b) for DIV and a mod b for MOD.
REQ-018 SHALL, for DIV/MOD with b == 0, go IDLE->RESP directly with rsp_err=1; rsp_result is all ones for DIV and a for MOD.
REQ-019 SHALL hold rsp_valid high for exactly one cycle in RESP, then return to IDLE; rsp_id/rsp_result/rsp_err SHALL be stable while rsp_valid is high, and rsp_err=0 for all non-error results.
REQ-020 SHALL not accept a new request in BUSY or RESP; the minimum accept-to-accept spacing SHALL be 2 cycles.
REQ-021 SHALL keep a requester that deasserts valid before being granted from affecting arbitration or priority.

Reset
REQ-022 SHALL, on rst, immediately force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, priority to requester 0, and divider state to 0.
REQ-023 SHALL abort any in-flight operation when rst is asserted mid-BUSY or mid-RESP; no response for it SHALL be issued after reset release.
REQ-024 SHALL hold reqN_ready low while rst is high.

Configuration
REQ-025 SHALL, with macro SHARED_ALU_DIVMOD_EN defined, implement DIV/MOD as in REQ-017/018.
REQ-026 SHALL, without SHARED_ALU_DIVMOD_EN, omit the divider and the BUSY state; DIV/MOD are accepted and go IDLE->RESP with rsp_err=1 and rsp_result=0, and SUB/MUL are unchanged.

Verification (WIDTH=8, macro defined unless noted)
REQ-027 SHALL cover: req0 SUB a=5 b=7 -> one cycle after accept: rsp_valid=1, rsp_id=0, rsp_result=0xFE, rsp_err=0.
REQ-028 SHALL cover: req1 MUL a=20 b=13 -> rsp_result=0x04, rsp_id=1; then DIV 200/7 -> 8 BUSY cycles, rsp_result=28; then MOD 200%7 -> rsp_result=4.
REQ-029 SHALL cover: both requesters valid continuously with SUB -> grants alternate 0,1,0,1, starting with 0 after reset; accepts spaced exactly 2 cycles.
REQ-030 SHALL cover: DIV a=9 b=0 -> rsp_err=1, rsp_result=0xFF, no BUSY cycles; MOD a=9 b=0 -> rsp_err=1, rsp_result=9.
REQ-031 SHALL cover: rst pulsed in the 4th BUSY cycle of a DIV -> all outputs 0 immediately, no rsp_valid afterwards, the next grant goes to requester 0.
REQ-032 SHALL cover, with the macro undefined: DIV 200/7 -> next cycle rsp_valid=1, rsp_err=1, rsp_result=0.

Source files
------------

// File: rtl/shared_alu_arbiter.sv
// ============================================================================
// Module   : shared_alu_arbiter
// Purpose  : Two-requester round-robin front end for one shared arithmetic
//            unit (SUB, MUL, and optionally an iterative DIV/MOD).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                      sole clock, rising edge
//   rst                      asynchronous active-high reset
//   reqN_valid/op/a/b        requester N operation (op: 0 SUB 1 MUL 2 DIV 3 MOD)
//   reqN_ready               combinational accept strobe (IDLE only)
//   rsp_valid                one-cycle result strobe, no back-pressure
//   rsp_id                   requester that owns the response
//   rsp_result               WIDTH-bit result
//   rsp_err                  divide-by-zero / unsupported-op flag
// Configuration
//   SHARED_ALU_DIVMOD_EN     when defined, builds the restoring divider and the
//                            BUSY state; otherwise DIV/MOD answer rsp_err=1,
//                            rsp_result=0 one cycle after acceptance.
// ============================================================================
`default_nettype none

module shared_alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err
);

  localparam logic [1:0] OP_SUB = 2'd0;
  localparam logic [1:0] OP_MUL = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd2;

`ifdef SHARED_ALU_DIVMOD_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2} state_t;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RESP = 2'd2} state_t;
`endif

  state_t           state_q;
  logic             prio_q;        // requester currently holding priority
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_err_q;

  // --------------------------------------------------------------------------
  // Round-robin arbitration. A requester that drops valid before being
  // granted simply never wins, so it cannot disturb the priority pointer.
  // --------------------------------------------------------------------------
  logic             grant0;
  logic             grant1;
  logic             accept_ok;
  logic             sel_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] sub_res;
  logic [WIDTH-1:0] mul_res;

  always_comb begin
    grant0  = req0_valid && (!prio_q || !req1_valid);
    grant1  = req1_valid && ( prio_q || !req0_valid);
    sel_id  = grant1;
    sel_op  = grant1 ? req1_op : req0_op;
    sel_a   = grant1 ? req1_a  : req0_a;
    sel_b   = grant1 ? req1_b  : req0_b;
    // Result width equals operand width, so only the low WIDTH bits survive.
    sub_res = sel_a - sel_b;
    mul_res = sel_a * sel_b;
  end

  assign accept_ok  = (state_q == S_IDLE) && !rst;
  assign req0_ready = accept_ok && grant0;
  assign req1_ready = accept_ok && grant1;

`ifdef SHARED_ALU_DIVMOD_EN
  // --------------------------------------------------------------------------
  // Restoring divider: one quotient bit per cycle, MSB first. The dividend is
  // shifted out of the quotient register while quotient bits shift in.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] div_rem_q;
  logic [WIDTH-1:0] div_quo_q;
  logic [WIDTH-1:0] div_dvs_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic             div_mod_q;     // 1: MOD, 0: DIV
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;

  always_comb begin
    div_shift = {div_rem_q, div_quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, div_dvs_q};
    // Bit WIDTH of the trial difference is set exactly when it went negative.
    if (!div_trial[WIDTH]) begin
      div_rem_d = div_trial[WIDTH-1:0];
    end else begin
      div_rem_d = div_shift[WIDTH-1:0];
    end
    div_quo_d = {div_quo_q[WIDTH-2:0], ~div_trial[WIDTH]};
  end
`endif

  // --------------------------------------------------------------------------
  // Control FSM with registered response outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prio_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
`ifdef SHARED_ALU_DIVMOD_EN
      div_rem_q    <= '0;
      div_quo_q    <= '0;
      div_dvs_q    <= '0;
      div_cnt_q    <= '0;
      div_mod_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          rsp_valid_q <= 1'b0;
          if (grant0 || grant1) begin
            prio_q   <= ~sel_id;
            rsp_id_q <= sel_id;
            case (sel_op)
              OP_SUB: begin
                rsp_result_q <= sub_res;
                rsp_err_q    <= 1'b0;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_RESP;
              end
              OP_MUL: begin
                rsp_result_q <= mul_res;
                rsp_err_q    <= 1'b0;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_RESP;
              end
              default: begin
`ifdef SHARED_ALU_DIVMOD_EN
                if (sel_b == '0) begin
                  // Divide by zero: all ones for DIV, dividend for MOD.
                  rsp_result_q <= (sel_op == OP_DIV) ? '1 : sel_a;
                  rsp_err_q    <= 1'b1;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= S_RESP;
                end else begin
                  div_rem_q <= '0;
                  div_quo_q <= sel_a;
                  div_dvs_q <= sel_b;
                  div_cnt_q <= '0;
                  div_mod_q <= sel_op[0];
                  state_q   <= S_BUSY;
                end
`else
                rsp_result_q <= '0;
                rsp_err_q    <= 1'b1;
                rsp_valid_q  <= 1'b1;
                state_q      <= S_RESP;
`endif
              end
            endcase
          end
        end
`ifdef SHARED_ALU_DIVMOD_EN
        S_BUSY: begin
          div_rem_q <= div_rem_d;
          div_quo_q <= div_quo_d;
          div_cnt_q <= div_cnt_q + CNT_W'(1);
          if (div_cnt_q == CNT_W'(WIDTH - 1)) begin
            rsp_result_q <= div_mod_q ? div_rem_d : div_quo_d;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            state_q      <= S_RESP;
          end
        end
`endif
        S_RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_shared_alu_arbiter.sv
// ============================================================================
// Module   : tb_shared_alu_arbiter
// Purpose  : Self-checking bench for shared_alu_arbiter (WIDTH=8). A timeline
//            reference model predicts grants, response cycle and response
//            contents from the arithmetic rules; directed steps are followed
//            by a randomized phase. Honours SHARED_ALU_DIVMOD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shared_alu_arbiter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         v   [2];
  logic [1:0]   op  [2];
  logic [W-1:0] a   [2];
  logic [W-1:0] b   [2];
  logic         req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err;
  logic [W-1:0] rsp_result;

  shared_alu_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (v[0]),
    .req0_op    (op[0]),
    .req0_a     (a[0]),
    .req0_b     (b[0]),
    .req1_valid (v[1]),
    .req1_op    (op[1]),
    .req1_a     (a[1]),
    .req1_b     (b[1]),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Timeline model state
  int           cyc       = 0;
  int           prio_m    = 0;
  int           next_free = 0;
  bit           rsp_pend  = 0;
  int           rsp_cyc   = 0;
  logic         rsp_id_m;
  logic [W-1:0] rsp_res_m;
  logic         rsp_err_m;
  int           grants[$];
  logic [W-1:0] last_res;
  logic         last_id;
  logic         last_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic rules: result, error flag, and cycles from accept to rsp_valid.
  function automatic void model_op(input logic [1:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y, output logic [W-1:0] res,
                                   output logic err, output int lat);
    int p;
    lat = 1;
    err = 1'b0;
    p   = 0;
    case (o)
      2'd0: p = int'(x) - int'(y) + 256;
      2'd1: p = int'(x) * int'(y);
      default: begin
`ifdef SHARED_ALU_DIVMOD_EN
        if (y == 0) begin
          err = 1'b1;
          p   = (o == 2'd2) ? 255 : int'(x);
        end else begin
          p   = (o == 2'd2) ? int'(x) / int'(y) : int'(x) % int'(y);
          lat = 1 + W;
        end
`else
        err = 1'b1;
        p   = 0;
`endif
      end
    endcase
    res = p[W-1:0];
  endfunction

  // One clock cycle: inputs already applied; check at negedge, then advance.
  task automatic step();
    int           win;
    bit           idle;
    bit           exp_v;
    logic [W-1:0] er;
    logic         ee;
    int           lat;
    @(negedge clk);
    idle = !rst && (cyc >= next_free);
    win  = -1;
    if (idle) begin
      if (v[prio_m])          win = prio_m;
      else if (v[1 - prio_m]) win = 1 - prio_m;
    end
    chk("req0_ready", req0_ready, win == 0);
    chk("req1_ready", req1_ready, win == 1);
    exp_v = rsp_pend && (rsp_cyc == cyc);
    chk("rsp_valid", rsp_valid, exp_v);
    if (exp_v) begin
      chk("rsp_id", rsp_id, rsp_id_m);
      chk("rsp_result", rsp_result, rsp_res_m);
      chk("rsp_err", rsp_err, rsp_err_m);
      rsp_pend = 0;
    end
    if (rsp_valid === 1'b1) begin
      last_res = rsp_result;
      last_id  = rsp_id;
      last_err = rsp_err;
    end
    if (win >= 0) begin
      model_op(op[win], a[win], b[win], er, ee, lat);
      rsp_pend  = 1;
      rsp_cyc   = cyc + lat;
      rsp_id_m  = (win == 1);
      rsp_res_m = er;
      rsp_err_m = ee;
      next_free = rsp_cyc + 1;
      prio_m    = 1 - win;
      grants.push_back(win);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Asynchronous reset with requesters active: outputs must clear at once.
  task automatic do_reset();
    v[0] = 1'b1;
    v[1] = 1'b1;
    rst  = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    rsp_pend  = 0;
    prio_m    = 0;
    next_free = 0;
    step();
    rst  = 1'b0;
    v[0] = 1'b0;
    v[1] = 1'b0;
  endtask

  // Single request from requester n; inputs scrambled after acceptance.
  task automatic run_one(input int n, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    last_res = 'x;
    last_id  = 1'bx;
    last_err = 1'bx;
    v[0] = 1'b0;
    v[1] = 1'b0;
    v[n] = 1'b1;
    op[n] = o;
    a[n]  = x;
    b[n]  = y;
    step();
    v[n] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      op[k] = 2'($urandom);
      a[k]  = W'($urandom);
      b[k]  = W'($urandom);
    end
    repeat (W + 3) step();
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; op[k] = 2'd0; a[k] = '0; b[k] = '0;
    end
    #2;
    do_reset();

    run_one(0, 2'd0, 8'd5, 8'd7);
    chk("sub_5_7", last_res, 8'hFE);
    chk("sub_id", last_id, 0);
    chk("sub_err", last_err, 0);

    run_one(1, 2'd1, 8'd20, 8'd13);
    chk("mul_20_13", last_res, 8'h04);
    chk("mul_id", last_id, 1);

    run_one(1, 2'd2, 8'd200, 8'd7);
`ifdef SHARED_ALU_DIVMOD_EN
    chk("div_200_7", last_res, 28);
    chk("div_err", last_err, 0);
`else
    chk("div_disabled_res", last_res, 0);
    chk("div_disabled_err", last_err, 1);
`endif

    run_one(0, 2'd3, 8'd200, 8'd7);
`ifdef SHARED_ALU_DIVMOD_EN
    chk("mod_200_7", last_res, 4);
`else
    chk("mod_disabled_res", last_res, 0);
`endif

    run_one(0, 2'd2, 8'd9, 8'd0);
    chk("div0_err", last_err, 1);
`ifdef SHARED_ALU_DIVMOD_EN
    chk("div0_res", last_res, 8'hFF);
`else
    chk("div0_res", last_res, 0);
`endif

    run_one(1, 2'd3, 8'd9, 8'd0);
    chk("mod0_err", last_err, 1);
`ifdef SHARED_ALU_DIVMOD_EN
    chk("mod0_res", last_res, 9);
`else
    chk("mod0_res", last_res, 0);
`endif

    // Both requesters hammering SUB: grants must alternate from 0.
    do_reset();
    grants.delete();
    v[0] = 1'b1; v[1] = 1'b1; op[0] = 2'd0; op[1] = 2'd0;
    for (int i = 0; i < 9; i++) begin
      a[0] = W'($urandom); b[0] = W'($urandom);
      a[1] = W'($urandom); b[1] = W'($urandom);
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    step();
    chk("rr_count", grants.size(), 5);
    for (int i = 0; i < 4; i++) begin
      chk("rr_order", (grants.size() > i) ? grants[i] : -1, i % 2);
    end

    // Reset during the 4th BUSY cycle of a DIV aborts it silently.
    grants.delete();
    v[1] = 1'b1; op[1] = 2'd2; a[1] = 8'd200; b[1] = 8'd7;
    step();
    v[1] = 1'b0;
    repeat (3) step();
    do_reset();
    grants.delete();
    v[0] = 1'b1; v[1] = 1'b1; op[0] = 2'd1; op[1] = 2'd1;
    step();
    chk("post_rst_grant", (grants.size() > 0) ? grants[0] : -1, 0);
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (W + 4) step();

    // Randomized phase.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        v[k]  = ($urandom_range(0, 9) < 6);
        op[k] = 2'($urandom);
        a[k]  = W'($urandom);
        b[k]  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      end
      step();
    end
    v[0] = 1'b0; v[1] = 1'b0;
    repeat (W + 4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
